// File: rtl/rand_sched_pkg.sv
// Shared types and constants for the random request scheduler and its LFSR step function.
package rand_sched_pkg;

  localparam int unsigned LFSR_W = 16;

  // Feedback taps of the 16-bit LFSR
  localparam int unsigned TAP_0 = 15;
  localparam int unsigned TAP_1 = 14;
  localparam int unsigned TAP_2 = 12;
  localparam int unsigned TAP_3 = 3;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StDraw,
    StGrant
  } state_e;

endpackage

// File: rtl/lfsr16_step.sv
// Combinational next-state function of the shared 16-bit LFSR (XNOR taps plus all-ones escape).
module lfsr16_step
  import rand_sched_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr,
  output logic [LFSR_W-1:0] nx
);

  logic fb;

  always_comb begin
    // The AND term folds the lock-up state into the sequence, giving the full 2**16 cycle
    fb = (lfsr[TAP_0] ~^ lfsr[TAP_1] ~^ lfsr[TAP_2] ~^ lfsr[TAP_3]) ^ (&lfsr[LFSR_W-2:0]);
    nx = {lfsr[LFSR_W-2:0], fb};
  end

endmodule

// File: rtl/rand_req_sched.sv
// Round-robin scheduler handing range-qualified LFSR samples to REQ_N requesters.
// Define RAND_REQ_SCHED_STATS_EN to add the saturating rej_cnt rejected-draw counter.
module rand_req_sched
  import rand_sched_pkg::*;
#(
  parameter int unsigned        REQ_N   = 4,
  parameter int unsigned        W       = 7,
  parameter int unsigned        LOW     = 90,
  parameter int unsigned        HIGH    = 127,
  parameter logic [LFSR_W-1:0]  SEED    = 16'd3,
  parameter int unsigned        MAX_TRY = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req,
  output logic [REQ_N-1:0] gnt,
  output logic [W-1:0]     rnd_data,
  output logic             rnd_miss,
  output logic             busy
`ifdef RAND_REQ_SCHED_STATS_EN
  ,
  output logic [15:0]      rej_cnt
`endif
);

  localparam int unsigned IDX_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int unsigned TRY_W = $clog2(MAX_TRY + 1);
  localparam int unsigned SPAN  = HIGH - LOW;

  localparam logic [W:0]       LOW_V    = LOW[W:0];
  localparam logic [W:0]       SPAN_V   = SPAN[W:0];
  localparam logic [W-1:0]     LOW_D    = LOW[W-1:0];
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQ_N - 1);

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]  nx;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [TRY_W-1:0]   try_q, try_d;
  logic [W-1:0]       rnd_q, rnd_d;
  logic               miss_q, miss_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [W-1:0]       samp;
  logic [W:0]         diff;
  logic               in_range;

  lfsr16_step u_step (
    .lfsr (lfsr_q),
    .nx   (nx)
  );

  // Offset from LOW in W+1 bits: samples below LOW wrap above any legal span
  always_comb begin
    samp     = nx[W-1:0];
    diff     = {1'b0, samp} - LOW_V;
    in_range = (diff <= SPAN_V);
  end

  // First set request at or after ptr, wrapping modulo REQ_N
  always_comb begin
    int unsigned      idx;
    logic [IDX_W-1:0] idx_b;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    idx_b    = '0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= REQ_N) idx = idx - REQ_N;
      idx_b = IDX_W'(idx);
      if (!pick_vld && req[idx_b]) begin
        pick     = idx_b;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    try_d   = try_q;
    rnd_d   = rnd_q;
    miss_d  = miss_q;
    unique case (state_q)
      StIdle: begin
        if (|req) state_d = StArb;
      end
      StArb: begin
        if (pick_vld) begin
          sel_d   = pick;
          try_d   = '0;
          state_d = StDraw;
        end else begin
          state_d = StIdle;
        end
      end
      StDraw: begin
        lfsr_d = nx;
        try_d  = try_q + 1'b1;
        if (in_range) begin
          rnd_d   = samp;
          miss_d  = 1'b0;
          state_d = StGrant;
        end else if (try_q == LAST_TRY) begin
          rnd_d   = LOW_D;
          miss_d  = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      ptr_q   <= '0;
      sel_q   <= '0;
      try_q   <= '0;
      rnd_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      try_q   <= try_d;
      rnd_q   <= rnd_d;
      miss_q  <= miss_d;
    end
  end

  // Outputs decode registered state only; req never reaches them combinationally
  always_comb begin
    gnt      = (state_q == StGrant) ? (REQ_N'(1) << sel_q) : '0;
    rnd_data = rnd_q;
    rnd_miss = (state_q == StGrant) && miss_q;
    busy     = (state_q != StIdle);
  end

`ifdef RAND_REQ_SCHED_STATS_EN
  logic [15:0] rej_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rej_q <= '0;
    end else if ((state_q == StDraw) && !in_range && (rej_q != 16'hFFFF)) begin
      rej_q <= rej_q + 16'd1;
    end
  end

  assign rej_cnt = rej_q;
`endif

endmodule

// File: tb/tb_rand_req_sched.sv
// Directed and randomized scoreboard bench for rand_req_sched (three parameterizations).
module tb_rand_req_sched;

  localparam logic [15:0] SEED = 16'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req0, req1, req2;
  logic [3:0] gnt0, gnt1, gnt2;
  logic [6:0] rnd0, rnd1, rnd2;
  logic       miss0, miss1, miss2;
  logic       busy0, busy1, busy2;
`ifdef RAND_REQ_SCHED_STATS_EN
  logic [15:0] rej0, rej1, rej2;
`endif

  rand_req_sched #(.REQ_N(4), .W(7), .LOW(0), .HIGH(127), .SEED(SEED), .MAX_TRY(8)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .req      (req0),
    .gnt      (gnt0),
    .rnd_data (rnd0),
    .rnd_miss (miss0),
    .busy     (busy0)
`ifdef RAND_REQ_SCHED_STATS_EN
    ,
    .rej_cnt  (rej0)
`endif
  );

  rand_req_sched #(.REQ_N(4), .W(7), .LOW(126), .HIGH(126), .SEED(SEED), .MAX_TRY(2)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .req      (req1),
    .gnt      (gnt1),
    .rnd_data (rnd1),
    .rnd_miss (miss1),
    .busy     (busy1)
`ifdef RAND_REQ_SCHED_STATS_EN
    ,
    .rej_cnt  (rej1)
`endif
  );

  rand_req_sched #(.REQ_N(4), .W(7), .LOW(90), .HIGH(127), .SEED(SEED), .MAX_TRY(8)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .req      (req2),
    .gnt      (gnt2),
    .rnd_data (rnd2),
    .rnd_miss (miss2),
    .busy     (busy2)
`ifdef RAND_REQ_SCHED_STATS_EN
    ,
    .rej_cnt  (rej2)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [3:0] g;
    logic [6:0] d;
    logic       m;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mlfsr;

  function automatic logic [15:0] mstep(input logic [15:0] s);
    logic fb;
    fb = ~(s[15] ^ s[14] ^ s[12] ^ s[3]) ^ (&s[14:0]);
    return {s[14:0], fb};
  endfunction

  function automatic logic [3:0] gnt_of(input int w);
    case (w)
      0:       return gnt0;
      1:       return gnt1;
      default: return gnt2;
    endcase
  endfunction

  function automatic logic [6:0] rnd_of(input int w);
    case (w)
      0:       return rnd0;
      1:       return rnd1;
      default: return rnd2;
    endcase
  endfunction

  function automatic logic miss_of(input int w);
    case (w)
      0:       return miss0;
      1:       return miss1;
      default: return miss2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Advances whole cycles, sampling on the falling edge, until gnt of DUT w is nonzero
  task automatic wait_gnt(input int w, input int budget, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (gnt_of(w) != 4'b0000) seen = 1'b1;
    end
    if (!seen) check("gnt_timeout", 32'(seen), 1);
  endtask

  task automatic sb_check(input int w, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_gnt"}, 32'(gnt_of(w)), 32'(e.g));
    check({tag, "_data"}, 32'(rnd_of(w)), 32'(e.d));
    check({tag, "_miss"}, 32'(miss_of(w)), 32'(e.m));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int grants;
    int age [4];

    rst  = 1'b0;
    req0 = '0;
    req1 = '0;
    req2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt0), 0);
    check("rst_data", 32'(rnd0), 0);
    check("rst_miss", 32'(miss0), 0);
    check("rst_busy", 32'(busy0), 0);
    rst = 1'b1;

    // Single requester, full range: first three draws from SEED
    req0 = 4'b0001;
    sb.push_back('{4'b0001, 7'd7, 1'b0});
    sb.push_back('{4'b0001, 7'd15, 1'b0});
    sb.push_back('{4'b0001, 7'd30, 1'b0});
    wait_gnt(0, 20, cyc);
    check("a_lat0", 32'(cyc), 3);
    sb_check(0, "a0");
    wait_gnt(0, 20, cyc);
    check("a_lat1", 32'(cyc), 4);
    sb_check(0, "a1");
    wait_gnt(0, 20, cyc);
    check("a_lat2", 32'(cyc), 4);
    sb_check(0, "a2");
    req0 = '0;

    // Fairness with all requesters held, from a fresh reset
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    mlfsr = SEED;
    req0  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      mlfsr = mstep(mlfsr);
      sb.push_back('{4'b0001 << (k % 4), mlfsr[6:0], 1'b0});
    end
    for (int k = 0; k < 5; k++) begin
      wait_gnt(0, 20, cyc);
      check("b_period", 32'(cyc), (k == 0) ? 3 : 4);
      sb_check(0, "b");
    end
    req0 = '0;

    // Narrow window, two tries: both draws rejected
    req1 = 4'b0001;
    sb.push_back('{4'b0001, 7'd126, 1'b1});
    wait_gnt(1, 20, cyc);
    check("c_lat", 32'(cyc), 4);
    sb_check(1, "c");
`ifdef RAND_REQ_SCHED_STATS_EN
    check("c_rej", 32'(rej1), 2);
`endif
    req1 = '0;

    // Reset while drawing aborts silently and restarts the LFSR
    req0 = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("d_busy_draw", 32'(busy0), 1);
    check("d_nognt_pre", 32'(gnt0), 0);
    rst  = 1'b0;
    req0 = '0;
    @(posedge clk);
    @(negedge clk);
    check("d_gnt_rst", 32'(gnt0), 0);
    check("d_busy_rst", 32'(busy0), 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("d_quiet", 32'(gnt0), 0);
    end
    mlfsr = mstep(SEED);
    req0  = 4'b0001;
    sb.push_back('{4'b0001, mlfsr[6:0], 1'b0});
    wait_gnt(0, 20, cyc);
    check("d_lat", 32'(cyc), 3);
    sb_check(0, "d");
    req0 = '0;

    // One-cycle request pulse: back to idle, LFSR untouched
    @(negedge clk);
    req0 = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req0 = '0;
    check("e_busy_arb", 32'(busy0), 1);
    @(posedge clk);
    @(negedge clk);
    check("e_idle", 32'(busy0), 0);
    check("e_nognt", 32'(gnt0), 0);
    repeat (2) begin
      @(negedge clk);
      check("e_quiet", 32'(gnt0), 0);
    end
    mlfsr = mstep(mlfsr);
    req0  = 4'b0010;
    sb.push_back('{4'b0010, mlfsr[6:0], 1'b0});
    wait_gnt(0, 20, cyc);
    check("e_lat", 32'(cyc), 3);
    sb_check(0, "e");
    req0 = '0;

    // Random protocol-abiding requesters against the default window
    grants = 0;
    for (int b = 0; b < 4; b++) age[b] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt2 != 4'b0000) begin
        grants++;
        check("f_onehot", 32'($onehot(gnt2)), 1);
        check("f_to_req", 32'(|(gnt2 & req2)), 1);
        if (miss2) check("f_miss_data", 32'(rnd2), 90);
        else check("f_range", 32'(rnd2 >= 7'd90), 1);
      end
      for (int b = 0; b < 4; b++) begin
        if (gnt2[b]) begin
          req2[b] = 1'b0;
          age[b]  = 0;
        end else if (req2[b]) begin
          age[b]++;
          if (age[b] > 60) begin
            check("f_starve", 32'(age[b]), 60);
            age[b] = 0;
          end
        end else if ($urandom_range(3) == 0) begin
          req2[b] = 1'b1;
        end
      end
    end
    req2 = '0;
    check("f_grants_seen", 32'(grants > 500), 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
